// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit scheduler:
//   state_t / ST_*        scheduler FSM encoding (IDLE -> SHIFT -> GAP -> IDLE)
//   TICK_START/TICK_DATA0 tick indices of the start bit and first data bit
//   log2_min1()           index width helper, never narrower than one bit
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_GAP   = 2'd2;

    localparam int unsigned TICK_START = 0;
    localparam int unsigned TICK_DATA0 = 1;

    // Width needed to index n items; at least 1 so single-bit buses stay legal.
    function automatic int unsigned log2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered priority pointer. The search starts
// at the pointer and wraps at NUM_REQ; on advance the pointer moves to one
// past the winner so the winner becomes lowest priority next time.
// Ports:
//   clk, rst       clock, asynchronous active-high reset (pointer -> 0)
//   req_i          request vector
//   advance_i      winner is being taken this cycle; update pointer
//   grant_c        one-hot winner (combinational)
//   grant_idx_c    index of winner (combinational)
//   any_c          at least one request present (combinational)
// ---------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic                              advance_i,
    output logic [NUM_REQ-1:0]                grant_c,
    output logic [log2_min1(NUM_REQ)-1:0]     grant_idx_c,
    output logic                              any_c
);

    localparam int unsigned IDX_W = log2_min1(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Rotating priority search starting at the pointer.
    always_comb begin
        int unsigned idx;
        logic        found;
        idx         = 0;
        found       = 1'b0;
        grant_c     = '0;
        grant_idx_c = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_i[IDX_W'(idx)]) begin
                found                  = 1'b1;
                grant_idx_c            = IDX_W'(idx);
                grant_c[IDX_W'(idx)]   = 1'b1;
            end
        end
        any_c = found;
    end

    // Pointer moves to winner+1, wrapping for non-power-of-two NUM_REQ.
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && any_c) begin
            if ((32'(grant_idx_c) + 1) >= NUM_REQ) begin
                ptr_d = '0;
            end else begin
                ptr_d = IDX_W'(32'(grant_idx_c) + 1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART TX line among NUM_REQ byte sources. A round-robin winner
// is latched in IDLE, then serialised LSB first as start/data/[parity]/stop,
// one bit per clk_bps strobe from the external baud generator, which this
// block enables through bps_start for the whole frame. An optional idle gap
// of IFG_CYC cycles separates frames.
// Build option: define UART_PARITY_EN to insert a parity bit (even, or odd
// when PARITY_ODD=1) between the last data bit and the stop bit.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req         level request per source
//   req_data    byte per source, source i at [i*DATA_W +: DATA_W]
//   grant       one-hot one-cycle pulse: byte of that source latched
//   bps_start   baud generator enable, high for the whole frame
//   clk_bps     one-cycle mid-bit strobe from the baud generator
//   tx          serial line, idle high
//   busy        high from grant through the last inter-frame gap cycle
//   done        one-cycle pulse after the stop bit completes
//   done_id     source index of the completed frame, valid with done
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned IFG_CYC    = 0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_W-1:0]     req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          bps_start,
    input  logic                          clk_bps,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [log2_min1(NUM_REQ)-1:0] done_id
);

    localparam int unsigned IDX_W = log2_min1(NUM_REQ);
`ifdef UART_PARITY_EN
    localparam int unsigned PAR_EN = 1;
`else
    localparam int unsigned PAR_EN = 0;
`endif
    // Tick map: start, DATA_W data ticks, optional parity, stop, done.
    localparam int unsigned PAR_TICK  = TICK_DATA0 + DATA_W;
    localparam int unsigned STOP_TICK = PAR_TICK + PAR_EN;
    localparam int unsigned DONE_TICK = STOP_TICK + 1;
    localparam int unsigned TICK_W    = log2_min1(DONE_TICK + 1);
    localparam int unsigned GAP_W     = 16;
    localparam int unsigned GAP_LAST  = (IFG_CYC > 0) ? (IFG_CYC - 1) : 0;

    // Arbiter interface
    logic [NUM_REQ-1:0] arb_grant_c;
    logic [IDX_W-1:0]   arb_idx_c;
    logic               arb_any_c;
    logic               arb_adv_c;
    logic [DATA_W-1:0]  byte_c;

    // State and datapath registers
    state_t              state_q,   state_d;
    logic [TICK_W-1:0]   tick_q,    tick_d;
    logic [DATA_W-1:0]   sh_q,      sh_d;
    logic [IDX_W-1:0]    src_q,     src_d;
    logic [GAP_W-1:0]    gap_q,     gap_d;
    logic [NUM_REQ-1:0]  grant_q,   grant_d;
    logic                bps_q,     bps_d;
    logic                tx_q,      tx_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic [IDX_W-1:0]    done_id_q, done_id_d;
`ifdef UART_PARITY_EN
    logic                par_q,     par_d;
`else
    logic                unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    rr_arbiter #(
        .NUM_REQ     (NUM_REQ)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .advance_i   (arb_adv_c),
        .grant_c     (arb_grant_c),
        .grant_idx_c (arb_idx_c),
        .any_c       (arb_any_c)
    );

    // Byte of the arbitration winner (one-hot select).
    always_comb begin
        byte_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_grant_c[i]) begin
                byte_c = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        sh_d      = sh_q;
        src_d     = src_q;
        gap_d     = gap_q;
        grant_d   = '0;
        bps_d     = bps_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        arb_adv_c = 1'b0;
`ifdef UART_PARITY_EN
        par_d     = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (arb_any_c) begin
                    arb_adv_c = 1'b1;
                    grant_d   = arb_grant_c;
                    sh_d      = byte_c;
                    src_d     = arb_idx_c;
                    tick_d    = '0;
                    bps_d     = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = ST_SHIFT;
`ifdef UART_PARITY_EN
                    par_d     = (^byte_c) ^ PARITY_ODD;
`endif
                end
            end

            ST_SHIFT: begin
                // tx only moves on a baud strobe; each strobe advances one tick.
                if (clk_bps) begin
                    tick_d = tick_q + 1'b1;
                    if (tick_q == TICK_W'(TICK_START)) begin
                        tx_d = 1'b0;
                    end else if (tick_q < TICK_W'(PAR_TICK)) begin
                        tx_d = sh_q[0];
                        sh_d = sh_q >> 1;
`ifdef UART_PARITY_EN
                    end else if (tick_q == TICK_W'(PAR_TICK)) begin
                        tx_d = par_q;
`endif
                    end else if (tick_q == TICK_W'(STOP_TICK)) begin
                        tx_d = 1'b1;
                    end else begin
                        // Stop bit has run a full period: close the frame.
                        tick_d    = '0;
                        tx_d      = 1'b1;
                        bps_d     = 1'b0;
                        done_d    = 1'b1;
                        done_id_d = src_q;
                        if (IFG_CYC == 0) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            tick_q    <= '0;
            sh_q      <= '0;
            src_q     <= '0;
            gap_q     <= '0;
            grant_q   <= '0;
            bps_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
`ifdef UART_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            sh_q      <= sh_d;
            src_q     <= src_d;
            gap_q     <= gap_d;
            grant_q   <= grant_d;
            bps_q     <= bps_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
`ifdef UART_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign bps_start = bps_q;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign done_id   = done_id_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Two schedulers: dut0 with no inter-frame gap, dut1 with a 10-cycle gap.
// A baud generator model strobes 26 cycles after bps_start rises and then
// every 51 cycles. Expected frames, winners and gaps come from a reference
// model of the protocol rules (bit list per byte, rotating priority pointer).
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NR   = 4;
    localparam int DW   = 8;
    localparam int IFG1 = 10;
`ifdef UART_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = DW + 2 + PB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NR-1:0]     req_0, req_1, grant_0, grant_1;
    logic [NR*DW-1:0]  data_0, data_1;
    logic              bps_0, bps_1, tx_0, tx_1, busy_0, busy_1, done_0, done_1;
    logic              cb_0 = 1'b0;
    logic              cb_1 = 1'b0;
    logic [1:0]        id_0, id_1;

    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .IFG_CYC(0)) dut0 (
        .clk(clk), .rst(rst), .req(req_0), .req_data(data_0), .grant(grant_0),
        .bps_start(bps_0), .clk_bps(cb_0), .tx(tx_0), .busy(busy_0),
        .done(done_0), .done_id(id_0));

    uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .IFG_CYC(IFG1)) dut1 (
        .clk(clk), .rst(rst), .req(req_1), .req_data(data_1), .grant(grant_1),
        .bps_start(bps_1), .clk_bps(cb_1), .tx(tx_1), .busy(busy_1),
        .done(done_1), .done_id(id_1));

    // Baud generator model, one counter per DUT.
    function automatic logic is_strobe(input int k);
        return (k == 26) || (k > 26 && ((k - 26) % 51) == 0);
    endfunction

    int bc0 = 0;
    int bc1 = 0;
    always @(posedge clk) begin
        if (!bps_0) begin bc0 <= 0; cb_0 <= 1'b0; end
        else begin bc0 <= bc0 + 1; cb_0 <= is_strobe(bc0 + 1); end
        if (!bps_1) begin bc1 <= 0; cb_1 <= 1'b0; end
        else begin bc1 <= bc1 + 1; cb_1 <= is_strobe(bc1 + 1); end
    end

    // View of the DUT currently under test.
    int sel = 0;
    logic [NR-1:0] m_grant;
    logic          m_tx, m_cb, m_done, m_busy, m_bps;
    logic [1:0]    m_id;
    assign m_grant = (sel != 0) ? grant_1 : grant_0;
    assign m_tx    = (sel != 0) ? tx_1    : tx_0;
    assign m_cb    = (sel != 0) ? cb_1    : cb_0;
    assign m_done  = (sel != 0) ? done_1  : done_0;
    assign m_busy  = (sel != 0) ? busy_1  : busy_0;
    assign m_bps   = (sel != 0) ? bps_1   : bps_0;
    assign m_id    = (sel != 0) ? id_1    : id_0;

    int n_assert = 0;
    int n_fail   = 0;
    int ptr [2];
    logic [NR*DW-1:0] dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ifg_of(input int s);
        return (s != 0) ? IFG1 : 0;
    endfunction

    // Reference frame: start 0, data LSB first, [parity], stop 1.
    function automatic logic [NBITS-1:0] frame_bits(input logic [DW-1:0] d);
        logic [NBITS-1:0] b;
        b = '0;
        b[0] = 1'b0;
        for (int i = 0; i < DW; i++) b[1+i] = d[i];
`ifdef UART_PARITY_EN
        b[DW+1] = ^d;
`endif
        b[NBITS-1] = 1'b1;
        return b;
    endfunction

    // Rotating-priority reference: first requester at or after p.
    function automatic int rr_pick(input logic [NR-1:0] mask, input int p);
        for (int k = 0; k < NR; k++) begin
            if (mask[(p + k) % NR]) return (p + k) % NR;
        end
        return 0;
    endfunction

    task automatic drive(input logic [NR-1:0] r, input logic [NR*DW-1:0] d);
        if (sel == 0) begin req_0 = r; data_0 = d; end
        else begin req_1 = r; data_1 = d; end
    endtask

    // Wait for the next baud strobe and the cycle in which the DUT has reacted.
    task automatic next_strobe(input logic hold, output bit ok, output bit steady);
        int n;
        n = 0;
        steady = 1'b1;
        while (m_cb !== 1'b1 && n < 200) begin
            if (m_tx !== hold || m_done !== 1'b0) steady = 1'b0;
            tick();
            n++;
        end
        ok = (n < 200);
        tick();
    endtask

    // Wait for a grant, check winner against the model; exp_gap>0 also checks
    // the cycle distance from the preceding done and an idle-high line.
    task automatic do_grant(input logic [NR-1:0] mask, input string tag,
                            input int exp_gap, output int idx);
        int   cyc;
        bit   tx_hi;
        logic last_busy;
        idx = rr_pick(mask, ptr[sel]);
        cyc = 0;
        tx_hi = 1'b1;
        last_busy = m_busy;
        while (m_grant === '0 && cyc < 3000) begin
            if (m_tx !== 1'b1) tx_hi = 1'b0;
            last_busy = m_busy;
            tick();
            cyc++;
        end
        chk({tag, "_grant"}, 32'(m_grant), 32'(1) << idx);
        chk({tag, "_busy_at_grant"}, 32'(m_busy), 32'(1));
        chk({tag, "_bps_at_grant"}, 32'(m_bps), 32'(1));
        if (exp_gap > 0) begin
            chk({tag, "_gap_cycles"}, 32'(cyc), 32'(exp_gap));
            chk({tag, "_gap_tx_high"}, 32'(tx_hi), 32'(1));
            chk({tag, "_busy_low_before"}, 32'(last_busy), 32'(0));
        end
        ptr[sel] = (idx + 1) % NR;
    endtask

    task automatic pulse_end(input string tag);
        tick();
        chk({tag, "_grant_pulse"}, 32'(m_grant), 32'(0));
    endtask

    task automatic run_frame(input int idx, input logic [DW-1:0] d, input string tag);
        logic [NBITS-1:0] bits;
        logic cur;
        bit ok, st, all_ok, all_st;
        bits = frame_bits(d);
        cur = 1'b1;
        all_ok = 1'b1;
        all_st = 1'b1;
        for (int k = 0; k < NBITS; k++) begin
            next_strobe(cur, ok, st);
            all_ok = all_ok & ok;
            all_st = all_st & st;
            chk($sformatf("%s_bit%0d", tag, k), 32'(m_tx), 32'(bits[k]));
            cur = bits[k];
        end
        next_strobe(cur, ok, st);
        all_ok = all_ok & ok;
        all_st = all_st & st;
        chk({tag, "_done"}, 32'(m_done), 32'(1));
        chk({tag, "_done_id"}, 32'(m_id), 32'(idx));
        chk({tag, "_bps_off"}, 32'(m_bps), 32'(0));
        chk({tag, "_tx_idle"}, 32'(m_tx), 32'(1));
        chk({tag, "_busy_at_done"}, 32'(m_busy), 32'(ifg_of(sel) > 0));
        chk({tag, "_strobes_seen"}, 32'(all_ok), 32'(1));
        chk({tag, "_tx_stable"}, 32'(all_st), 32'(1));
    endtask

    initial begin
        int          w;
        logic [DW-1:0] old;
        logic [NR-1:0] mask;
        bit          quiet;

        rst = 1'b1;
        req_0 = '0; req_1 = '0; data_0 = '0; data_1 = '0;
        ptr[0] = 0; ptr[1] = 0;
        sel = 0;
        repeat (3) tick();
        chk("rst_tx", 32'(tx_0), 32'(1));
        chk("rst_bps", 32'(bps_0), 32'(0));
        chk("rst_grant", 32'(grant_0), 32'(0));
        chk("rst_busy", 32'(busy_0), 32'(0));
        chk("rst_done", 32'(done_0), 32'(0));
        chk("rst_done_id", 32'(id_0), 32'(0));
        rst = 1'b0;
        repeat (2) tick();

        // Single frame from source 0.
        dat = '0;
        dat[7:0] = 8'hA5;
        drive(4'b0001, dat);
        do_grant(4'b0001, "single", 0, w);
        drive(4'b0000, dat);
        pulse_end("single");
        run_frame(w, 8'hA5, "single");

        // Round-robin with all requests held; the winner reloads its byte.
        for (int i = 0; i < NR; i++) dat[i*DW +: DW] = DW'($urandom);
        drive(4'b1111, dat);
        for (int n = 0; n < 5; n++) begin
            do_grant(4'b1111, $sformatf("rr%0d", n), (n > 0) ? ifg_of(sel) + 1 : 0, w);
            old = dat[w*DW +: DW];
            dat[w*DW +: DW] = DW'($urandom);
            drive((n == 4) ? 4'b0000 : 4'b1111, dat);
            pulse_end($sformatf("rr%0d", n));
            run_frame(w, old, $sformatf("rr%0d", n));
        end

        // Pointer wrap: 3, then 0, then 3.
        tick();
        drive(4'b1000, dat);
        do_grant(4'b1000, "wrap_a", 0, w);
        old = dat[w*DW +: DW];
        dat[w*DW +: DW] = DW'($urandom);
        drive(4'b1001, dat);
        pulse_end("wrap_a");
        run_frame(w, old, "wrap_a");
        do_grant(4'b1001, "wrap_b", 1, w);
        old = dat[w*DW +: DW];
        drive(4'b1000, dat);
        pulse_end("wrap_b");
        run_frame(w, old, "wrap_b");
        do_grant(4'b1000, "wrap_c", 1, w);
        old = dat[w*DW +: DW];
        drive(4'b0000, dat);
        pulse_end("wrap_c");
        run_frame(w, old, "wrap_c");

        // Parity-sensitive bytes.
        tick();
        dat[2*DW +: DW] = 8'h07;
        drive(4'b0100, dat);
        do_grant(4'b0100, "par07", 0, w);
        drive(4'b0000, dat);
        pulse_end("par07");
        run_frame(w, 8'h07, "par07");
        tick();
        dat[2*DW +: DW] = 8'h03;
        drive(4'b0100, dat);
        do_grant(4'b0100, "par03", 0, w);
        drive(4'b0000, dat);
        pulse_end("par03");
        run_frame(w, 8'h03, "par03");

        // Random request masks and bytes.
        for (int n = 0; n < 5; n++) begin
            tick();
            mask = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) dat[i*DW +: DW] = DW'($urandom);
            drive(mask, dat);
            do_grant(mask, $sformatf("rnd%0d", n), 0, w);
            old = dat[w*DW +: DW];
            drive(4'b0000, dat);
            pulse_end($sformatf("rnd%0d", n));
            run_frame(w, old, $sformatf("rnd%0d", n));
        end

        // Inter-frame gap on dut1: two back-to-back requests.
        sel = 1;
        tick();
        for (int i = 0; i < NR; i++) dat[i*DW +: DW] = DW'($urandom);
        drive(4'b0011, dat);
        do_grant(4'b0011, "ifg_a", 0, w);
        old = dat[w*DW +: DW];
        drive(4'b0010, dat);
        pulse_end("ifg_a");
        run_frame(w, old, "ifg_a");
        do_grant(4'b0010, "ifg_b", IFG1 + 1, w);
        old = dat[w*DW +: DW];
        drive(4'b0000, dat);
        pulse_end("ifg_b");
        run_frame(w, old, "ifg_b");

        // Reset in the middle of a frame on dut0 (data tick 4 sends bit 3 = 0).
        sel = 0;
        tick();
        dat[2*DW +: DW] = 8'h35;
        drive(4'b0100, dat);
        do_grant(4'b0100, "abort", 0, w);
        drive(4'b0000, dat);
        pulse_end("abort");
        begin
            logic [NBITS-1:0] bits;
            logic cur;
            bit ok, st;
            bits = frame_bits(8'h35);
            cur = 1'b1;
            for (int k = 0; k <= 4; k++) begin
                next_strobe(cur, ok, st);
                chk($sformatf("abort_bit%0d", k), 32'(m_tx), 32'(bits[k]));
                cur = bits[k];
            end
        end
        rst = 1'b1;
        #1;
        chk("abort_rst_tx", 32'(tx_0), 32'(1));
        chk("abort_rst_bps", 32'(bps_0), 32'(0));
        chk("abort_rst_busy", 32'(busy_0), 32'(0));
        quiet = 1'b1;
        repeat (3) begin
            tick();
            if (done_0 !== 1'b0 || tx_0 !== 1'b1 || bps_0 !== 1'b0) quiet = 1'b0;
        end
        rst = 1'b0;
        ptr[0] = 0;
        ptr[1] = 0;
        repeat (60) begin
            tick();
            if (done_0 !== 1'b0 || tx_0 !== 1'b1 || bps_0 !== 1'b0) quiet = 1'b0;
        end
        chk("abort_no_done", 32'(quiet), 32'(1));

        for (int i = 0; i < NR; i++) dat[i*DW +: DW] = DW'($urandom);
        drive(4'b0010, dat);
        do_grant(4'b0010, "post", 0, w);
        old = dat[w*DW +: DW];
        drive(4'b0000, dat);
        pulse_end("post");
        run_frame(w, old, "post");

        repeat (5) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
